// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file: default sizes,
// FSM state encoding and the hard-wired zero register address.
package rf_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int ZERO_ADDR  = 0;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } rf_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One read port: storage mux result, zero-register and INIT masking, and the
// optional write-through bypass enabled by the REGFILE_BYPASS_EN macro.
module rf_read_port
   import rf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              run,
   input  logic [ADDR_W-1:0] ra,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              busy_bit,
`ifdef REGFILE_BYPASS_EN
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              issue_vld,
   input  logic [ADDR_W-1:0] issue_rd,
`endif
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_busy
);

   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_ADDR);

   // NOTE: outputs get a default before any branch so no latch is inferred.
   always_comb begin
      rd_data = '0;
      rd_busy = 1'b0;
      if (run && ra != ZERO) begin
`ifdef REGFILE_BYPASS_EN
         // ra is non-zero here, so a match also implies a non-zero write address
         if (wr_en && wr_addr == ra) begin
            rd_data = wr_data;
            rd_busy = issue_vld && (issue_rd == wr_addr);
         end else begin
            rd_data = mem_data;
            rd_busy = busy_bit;
         end
`else
         rd_data = mem_data;
         rd_busy = busy_bit;
`endif
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with N combinational read ports, pending-write scoreboard and a
// post-reset clear walker. Define REGFILE_BYPASS_EN for write-to-read bypass.
module reg_file_sb
   import rf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = 2
) (
   input  logic                     Clk,
   input  logic                     Rst,
   output logic                     Ready,
   input  logic [NUM_RD*ADDR_W-1:0] Ra,
   output logic [NUM_RD*DATA_W-1:0] Rd_Data,
   output logic [NUM_RD-1:0]        Rd_Busy,
   input  logic                     RegWr,
   input  logic [ADDR_W-1:0]        Rw,
   input  logic [DATA_W-1:0]        busW,
   input  logic                     Issue_Vld,
   input  logic [ADDR_W-1:0]        Issue_Rd
);

   localparam int                DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO  = ADDR_W'(ZERO_ADDR);

   rf_state_e         state, state_nx;
   logic [ADDR_W-1:0] clr_idx;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              run, wr_ok, iss_ok;

   assign run    = (state == ST_RUN);
   assign wr_ok  = run && RegWr && (Rw != ZERO);
   assign iss_ok = run && Issue_Vld && (Issue_Rd != ZERO);
   assign Ready  = run;

   always_ff @(posedge Clk) begin
      if (Rst) state <= ST_INIT;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_INIT: if (clr_idx == '1) state_nx = ST_RUN;
         ST_RUN:  state_nx = ST_RUN;
         default: state_nx = ST_INIT;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst)                   clr_idx <= '0;
      else if (state == ST_INIT) clr_idx <= clr_idx + 1'b1;
   end

   // NOTE: the array has no reset term; the walker clears it one entry per
   // cycle so it can map onto RAM-style storage.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         if (state == ST_INIT) mem[clr_idx] <= '0;
         else if (wr_ok)       mem[Rw]      <= busW;
      end
   end

   // NOTE: both updates are non-blocking, so when Issue_Rd == Rw the later
   // set overrides the clear and the new issue stays pending.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         busy <= '0;
      end else begin
         if (wr_ok)  busy[Rw]       <= 1'b0;
         if (iss_ok) busy[Issue_Rd] <= 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra_i;
      assign ra_i = Ra[i*ADDR_W +: ADDR_W];

      rf_read_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_port (
         .run       (run),
         .ra        (ra_i),
         .mem_data  (mem[ra_i]),
         .busy_bit  (busy[ra_i]),
`ifdef REGFILE_BYPASS_EN
         .wr_en     (RegWr),
         .wr_addr   (Rw),
         .wr_data   (busW),
         .issue_vld (Issue_Vld),
         .issue_rd  (Issue_Rd),
`endif
         .rd_data   (Rd_Data[i*DATA_W +: DATA_W]),
         .rd_busy   (Rd_Busy[i])
      );
   end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single-write/two-read integer register file.
- Adds:
  - explicit address ports and N read ports;
  - posedge write with optional write-to-read bypass;
  - a pending-write scoreboard (busy bits) for the pipelined core;
  - a sequential clear-after-reset walker, so the array can map to RAM-style storage.
- Sits between decode (read/issue) and writeback (write/clear).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)

Ports:
- Clk  in  1  single clock, all state on rising edge
- Rst  in  1  synchronous reset, active-high
- Ready  out  1  high once the post-reset clear is complete
- Ra  in  NUM_RD*ADDR_W  read addresses; port i = Ra[i*ADDR_W +: ADDR_W]
- Rd_Data  out  NUM_RD*DATA_W  read data per port, combinational from Ra
- Rd_Busy  out  NUM_RD  scoreboard busy bit of each read address
- RegWr  in  1  write enable
- Rw  in  ADDR_W  write address
- busW  in  DATA_W  write data
- Issue_Vld  in  1  instruction issued with destination Issue_Rd
- Issue_Rd  in  ADDR_W  destination to mark pending

Behaviour:
- The only clock is Clk. Rst is synchronous and active-high.
- FSM states: INIT, RUN.
- Rst=1 at an edge:
  - state <= INIT, Clr_Idx <= 0, all busy bits <= 0, Ready <= 0.
  - Applies from any state, including mid-INIT or mid-operation.
- INIT:
  - Each cycle writes 0 to register[Clr_Idx] and increments Clr_Idx.
  - When Clr_Idx == depth-1 the final entry is cleared, then state <= RUN and Ready <= 1.
  - Clear takes exactly 2**ADDR_W cycles after Rst deasserts (32 for the default).
  - RegWr and Issue_Vld are ignored; Rd_Data = 0 and Rd_Busy = 0 on all ports.
- RUN, write:
  - RegWr=1 and Rw != 0: register[Rw] <= busW at the rising edge.
  - Writes to address 0 are dropped; register 0 always reads 0 and is never busy.
- RUN, read:
  - Rd_Data[i] = register[Ra_i], combinational, zero latency.
  - Ra_i == 0 gives 0.
- Scoreboard:
  - Issue_Vld=1 and Issue_Rd != 0: busy[Issue_Rd] <= 1.
  - RegWr=1 and Rw != 0: busy[Rw] <= 0.
  - Same edge, Issue_Rd == Rw: busy stays 1 (the new issue wins); the data write still happens.
  - Rd_Busy[i] = busy[Ra_i], combinational.
  - Busy for a given address reflects the state after the most recent edge.
- Multiple read ports may share an address. All ports return identical data.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined, in RUN, when RegWr=1, Rw != 0 and Ra_i == Rw:
  - Rd_Data[i] = busW in the same cycle (write-through).
  - Rd_Busy[i] = 0, unless Issue_Vld=1 with Issue_Rd == Rw.
- Undefined:
  - Reads return the pre-write register value until the edge.
  - Rd_Busy reflects stored busy bits only.
  - Writeback-to-decode needs one extra cycle.

Decomposition:
- Shared package (rf_pkg):
  - default DATA_W/ADDR_W constants;
  - FSM state encoding (ST_INIT=1'b0, ST_RUN=1'b1);
  - ZERO_ADDR constant.
- One sub-module, rf_read_port: a single port's mux, zero-address masking, INIT masking and optional bypass. It is instantiated NUM_RD times in a generate loop.
- The storage array, clear walker and scoreboard stay in the top module.

Test Plan:
- Reset, then hold Rst=0:
  - Ready=0 for exactly 32 cycles, then 1.
  - During INIT, drive RegWr=1, Rw=5, busW=32'hDEAD; afterwards reg 5 reads 0.
- Post-Ready:
  - Write Rw=3, busW=32'h1234_5678, then read Ra0=3, Ra1=3 → both return 32'h1234_5678.
  - Write Rw=0, busW=32'hFFFF_FFFF → Rd_Data for Ra=0 stays 0.
- Scoreboard:
  - Issue_Rd=7 → next cycle Rd_Busy for Ra=7 = 1.
  - RegWr Rw=7 → next cycle Rd_Busy = 0.
  - Issue_Rd=7 and RegWr Rw=7 on the same edge → Rd_Busy stays 1 and data is updated.
- Bypass (REGFILE_BYPASS_EN):
  - RegWr Rw=9, busW=32'hA5A5_A5A5 with Ra0=9 in the same cycle → Rd_Data0 = 32'hA5A5_A5A5 combinationally.
  - Without the macro → Rd_Data0 = old value that cycle, new value the next.
- Mid-operation reset:
  - Fill regs 1..31 and mark 4 busy, then pulse Rst for one cycle mid-INIT (Clr_Idx=10).
  - Result: INIT restarts, 32 more cycles, all registers 0, all busy 0.
- Parameters ADDR_W=3, NUM_RD=3:
  - Clear lasts 8 cycles.
  - Three simultaneous reads of distinct written addresses return the correct values.
